// File: rtl/reg_wb_arbiter_pkg.sv
// Shared core package for the register writeback arbiter: register-file
// geometry and the default starvation limit for the multi-cycle port.
package reg_wb_arbiter_pkg;

  localparam int ADDR_W           = 5;
  localparam int DATA_W           = 64;
  localparam int NUM_REGS         = 1 << ADDR_W;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Bundle of writeback request, allocation, decode-probe and register-file
// signals around the arbiter. The arbiter uses the slave modport; the core
// side (pipeline, multi-cycle units, decode, register file) uses master.
interface reg_wb_arbiter_if;
  import reg_wb_arbiter_pkg::*;

  // pipeline writeback request
  logic      p_valid;
  reg_addr_t p_addr;
  reg_data_t p_data;
  logic      p_ready;
  // multi-cycle unit writeback request
  logic      m_valid;
  reg_addr_t m_addr;
  reg_data_t m_data;
  logic      m_ready;
  // multi-cycle destination allocation
  logic      alloc_valid;
  reg_addr_t alloc_addr;
  // decode-side busy probes
  reg_addr_t chk_addr_1;
  reg_addr_t chk_addr_2;
  logic      chk_busy_1;
  logic      chk_busy_2;
  // register-file write port and error flag
  logic      wb_we;
  reg_addr_t wb_addr;
  reg_data_t wb_data;
  logic      err;

  modport slave (
    input  p_valid, p_addr, p_data,
    output p_ready,
    input  m_valid, m_addr, m_data,
    output m_ready,
    input  alloc_valid, alloc_addr,
    input  chk_addr_1, chk_addr_2,
    output chk_busy_1, chk_busy_2,
    output wb_we, wb_addr, wb_data, err
  );

  modport master (
    output p_valid, p_addr, p_data,
    input  p_ready,
    output m_valid, m_addr, m_data,
    input  m_ready,
    output alloc_valid, alloc_addr,
    output chk_addr_1, chk_addr_2,
    input  chk_busy_1, chk_busy_2,
    input  wb_we, wb_addr, wb_data, err
  );

endinterface

// File: rtl/reg_wb_arbiter_busy_table.sv
// reg_busy_table: scoreboard of registers with an outstanding multi-cycle
// write. Entry 0 is never busy (x0 is hardwired).
// Optional macro WBARB_BUSY_BYPASS_EN: a clearing handshake in the current
// cycle already hides the busy bit from the decode probes.
module reg_busy_table
  import reg_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      alloc_valid,
  input  reg_addr_t alloc_addr,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  input  reg_addr_t chk_addr_1,
  input  reg_addr_t chk_addr_2,
  input  reg_addr_t chk_addr_p,
  output logic      chk_busy_1,
  output logic      chk_busy_2,
  output logic      busy_p
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                bypass_1;
  logic                bypass_2;

  // Next busy state: clear on completion first so a same-cycle allocation wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid)
      busy_d[clr_addr] = 1'b0;
    if (alloc_valid && (alloc_addr != '0))
      busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy vector register, cleared asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      busy_q <= '0;
    else
      busy_q <= busy_d;
  end

`ifdef WBARB_BUSY_BYPASS_EN
  assign bypass_1 = clr_valid && (clr_addr == chk_addr_1) &&
                    !(alloc_valid && (alloc_addr == chk_addr_1));
  assign bypass_2 = clr_valid && (clr_addr == chk_addr_2) &&
                    !(alloc_valid && (alloc_addr == chk_addr_2));
`else
  assign bypass_1 = 1'b0;
  assign bypass_2 = 1'b0;
`endif

  assign chk_busy_1 = (chk_addr_1 != '0) && busy_q[chk_addr_1] && !bypass_1;
  assign chk_busy_2 = (chk_addr_2 != '0) && busy_q[chk_addr_2] && !bypass_2;
  // Registered state only: the error check looks at what was busy before this edge.
  assign busy_p     = (chk_addr_p != '0) && busy_q[chk_addr_p];

endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares one register-file write port between the pipeline
// (priority) and a multi-cycle unit that is forced through after
// STARVE_LIMIT consecutive lost cycles. Tracks busy destinations for decode
// and flags pipeline writes that race a pending multi-cycle write.
// Optional macro WBARB_BUSY_BYPASS_EN (see reg_busy_table).
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  reg_wb_arbiter_if.slave   bus
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_d;
  logic             m_grant;
  logic             p_hs;
  logic             m_hs;
  reg_addr_t        win_addr;
  reg_data_t        win_data;
  logic             win_write;
  logic             p_busy;

  // Grant selection: pipeline wins unless the multi-cycle unit has starved.
  always_comb begin
    m_grant = !rst && bus.m_valid &&
              (!bus.p_valid || (starve_cnt == CNT_MAX));
    m_hs    = m_grant;
    p_hs    = !rst && bus.p_valid && !m_grant;
    if (m_hs) begin
      win_addr = bus.m_addr;
      win_data = bus.m_data;
    end else begin
      win_addr = bus.p_addr;
      win_data = bus.p_data;
    end
    win_write = (p_hs || m_hs) && (win_addr != '0);
  end

  assign bus.p_ready = !m_grant;
  assign bus.m_ready = m_grant;

  // Starvation counter: count lost cycles, saturate, drop to 0 otherwise.
  always_comb begin
    starve_cnt_d = '0;
    if (bus.m_valid && !m_grant)
      starve_cnt_d = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      starve_cnt <= '0;
    else
      starve_cnt <= starve_cnt_d;
  end

  // Writeback register: strobe follows the handshake, address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_we   <= 1'b0;
      bus.wb_addr <= '0;
      bus.wb_data <= '0;
    end else begin
      bus.wb_we <= win_write;
      if (win_write) begin
        bus.wb_addr <= win_addr;
        bus.wb_data <= win_data;
      end
    end
  end

  // Sticky error: pipeline committed to a register still owed a multi-cycle result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.err <= 1'b0;
    else if (p_hs && (bus.p_addr != '0) && p_busy)
      bus.err <= 1'b1;
  end

  reg_busy_table u_busy (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (bus.alloc_valid),
    .alloc_addr  (bus.alloc_addr),
    .clr_valid   (m_hs),
    .clr_addr    (bus.m_addr),
    .chk_addr_1  (bus.chk_addr_1),
    .chk_addr_2  (bus.chk_addr_2),
    .chk_addr_p  (bus.p_addr),
    .chk_busy_1  (bus.chk_busy_1),
    .chk_busy_2  (bus.chk_busy_2),
    .busy_p      (p_busy)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter: directed stimulus with a writeback
// scoreboard (expected writes queued at handshake, popped at wb_we).
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  wb_t  exp_q[$];

  reg_wb_arbiter_if bus ();

  reg_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WBARB_BUSY_BYPASS_EN
  localparam logic BYP_EXP = 1'b0;
`else
  localparam logic BYP_EXP = 1'b1;
`endif

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One arbitration cycle: check readies, queue expected write, clock, check writeback.
  task automatic drive_cycle(input string tag, input logic exp_pr, input logic exp_mr);
    logic exp_we;
    wb_t  e;
    wb_t  got;
    #1;
    check_val({tag, "_p_ready"}, bus.p_ready, exp_pr);
    check_val({tag, "_m_ready"}, bus.m_ready, exp_mr);
    exp_we = 1'b0;
    if (bus.m_valid && exp_mr && bus.m_addr != 5'd0) begin
      e.addr = bus.m_addr; e.data = bus.m_data; exp_q.push_back(e); exp_we = 1'b1;
    end else if (bus.p_valid && exp_pr && !exp_mr && bus.p_addr != 5'd0) begin
      e.addr = bus.p_addr; e.data = bus.p_data; exp_q.push_back(e); exp_we = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val({tag, "_wb_we"}, bus.wb_we, exp_we);
    if (bus.wb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        got = exp_q.pop_front();
        check_val({tag, "_wb_addr"}, bus.wb_addr, got.addr);
        check_val({tag, "_wb_data"}, bus.wb_data, got.data);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.p_valid = 0; bus.p_addr = '0; bus.p_data = '0;
    bus.m_valid = 0; bus.m_addr = '0; bus.m_data = '0;
    bus.alloc_valid = 0; bus.alloc_addr = '0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    idle_inputs();
    bus.chk_addr_1 = '0;
    bus.chk_addr_2 = '0;
    bus.m_valid = 1;
    bus.p_valid = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state
    check_val("rst_wb_we", bus.wb_we, 0);
    check_val("rst_wb_addr", bus.wb_addr, 0);
    check_val("rst_wb_data", bus.wb_data, 0);
    check_val("rst_err", bus.err, 0);
    check_val("rst_p_ready", bus.p_ready, 1);
    check_val("rst_m_ready", bus.m_ready, 0);
    idle_inputs();
    rst = 1'b0;

    // simple pipeline write
    bus.p_valid = 1; bus.p_addr = 5'd5; bus.p_data = 64'hAA;
    drive_cycle("p_w5", 1, 0);
    idle_inputs();

    // pipeline write to x0 completes without strobing
    bus.p_valid = 1; bus.p_addr = 5'd0; bus.p_data = 64'hFF;
    drive_cycle("p_x0", 1, 0);
    check_val("p_x0_addr_hold", bus.wb_addr, 5'd5);
    idle_inputs();

    // starvation: m waits 4 cycles, then is forced through
    bus.m_valid = 1; bus.m_addr = 5'd7; bus.m_data = 64'h7777;
    for (int i = 0; i < 4; i++) begin
      bus.p_valid = 1; bus.p_addr = 5'(10 + i); bus.p_data = 64'h1000 + 64'(i);
      drive_cycle($sformatf("starve_%0d", i), 1, 0);
    end
    bus.p_addr = 5'd20; bus.p_data = 64'h2020;
    drive_cycle("starve_grant", 0, 1);
    bus.m_valid = 0;
    drive_cycle("starve_p_after", 1, 0);
    idle_inputs();

    // m alone gets immediate grant
    bus.m_valid = 1; bus.m_addr = 5'd8; bus.m_data = 64'h8888_0000_1234_5678;
    drive_cycle("m_alone", 0, 1);
    idle_inputs();

    // busy tracking and clear timing
    bus.chk_addr_1 = 5'd9; bus.chk_addr_2 = 5'd0;
    bus.alloc_valid = 1; bus.alloc_addr = 5'd9;
    #1;
    check_val("busy9_pre", bus.chk_busy_1, 0);
    drive_cycle("alloc9", 1, 0);
    bus.alloc_valid = 0;
    check_val("busy9_set", bus.chk_busy_1, 1);
    check_val("busy_x0", bus.chk_busy_2, 0);
    bus.m_valid = 1; bus.m_addr = 5'd9; bus.m_data = 64'h99;
    #1;
    check_val("busy9_clr_same", bus.chk_busy_1, BYP_EXP);
    drive_cycle("m_w9", 0, 1);
    check_val("busy9_clr_next", bus.chk_busy_1, 0);
    idle_inputs();

    // pipeline writes a busy register -> sticky err
    bus.chk_addr_1 = 5'd3;
    bus.alloc_valid = 1; bus.alloc_addr = 5'd3;
    drive_cycle("alloc3", 1, 0);
    idle_inputs();
    check_val("err_pre", bus.err, 0);
    bus.p_valid = 1; bus.p_addr = 5'd3; bus.p_data = 64'h33;
    drive_cycle("p_w3_busy", 1, 0);
    check_val("err_set", bus.err, 1);
    idle_inputs();
    drive_cycle("idle_a", 1, 0);
    drive_cycle("idle_b", 1, 0);
    check_val("err_sticky", bus.err, 1);
    check_val("busy3_still", bus.chk_busy_1, 1);

    // mid-stream async reset with wb_we=1 and busy[3]=1
    bus.p_valid = 1; bus.p_addr = 5'd3; bus.p_data = 64'h3333;
    drive_cycle("p_w3_again", 1, 0);
    bus.p_valid = 1; bus.p_addr = 5'd4; bus.p_data = 64'h44;
    bus.m_valid = 1; bus.m_addr = 5'd6; bus.m_data = 64'h66;
    #1;
    rst = 1'b1;
    #1;
    check_val("arst_wb_we", bus.wb_we, 0);
    check_val("arst_wb_addr", bus.wb_addr, 0);
    check_val("arst_wb_data", bus.wb_data, 0);
    check_val("arst_err", bus.err, 0);
    check_val("arst_busy3", bus.chk_busy_1, 0);
    check_val("arst_p_ready", bus.p_ready, 1);
    check_val("arst_m_ready", bus.m_ready, 0);
    @(posedge clk);
    #1;
    check_val("arst_hold_we", bus.wb_we, 0);
    idle_inputs();
    rst = 1'b0;

    // resume after reset
    bus.m_valid = 1; bus.m_addr = 5'd15; bus.m_data = 64'hF00D;
    drive_cycle("post_m", 0, 1);
    idle_inputs();
    bus.p_valid = 1; bus.p_addr = 5'd12; bus.p_data = 64'hC0DE;
    drive_cycle("post_p", 1, 0);
    check_val("post_err", bus.err, 0);
    idle_inputs();

    check_val("sb_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive lost cycles after which the multi-cycle port is forced a grant.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports p_valid/p_addr/p_data  input  1/5/64  pipeline writeback request (rd, value).
REQ-005 SHALL have port p_ready  output  1  pipeline request accepted this cycle.
REQ-006 SHALL have ports m_valid/m_addr/m_data  input  1/5/64  multi-cycle unit (div/load) writeback request.
REQ-007 SHALL have port m_ready  output  1  multi-cycle request accepted this cycle.
REQ-008 SHALL have ports alloc_valid/alloc_addr  input  1/5  multi-cycle op issued; mark rd busy.
REQ-009 SHALL have ports chk_addr_1/chk_addr_2  input  5/5  source regs probed by decode.
REQ-010 SHALL have ports chk_busy_1/chk_busy_2  output  1/1  probed reg has a pending multi-cycle write.
REQ-011 SHALL have ports wb_we/wb_addr/wb_data  output  1/5/64  drive register-file write port.
REQ-012 SHALL have port err  output  1  sticky: pipeline wrote a busy register.

Function
REQ-013 SHALL grant m when m_valid and (not p_valid or starve_cnt == STARVE_LIMIT); otherwise grant p; at most one handshake per cycle.
REQ-014 SHALL drive p_ready = not m-grant, m_ready = m-grant, combinationally from current valids and starve_cnt.
REQ-015 SHALL hold requests: a valid requester not accepted keeps valid/addr/data stable until ready.
REQ-016 SHALL increment starve_cnt (saturating at STARVE_LIMIT) each cycle m_valid and not m_ready; clear it on m handshake or when m_valid low.
REQ-017 SHALL register winner on posedge: wb_we = 1 if a handshake occurred with addr != 0, else 0; wb_addr/wb_data load only on such a write and otherwise hold.
REQ-018 SHALL accept writes to x0 (handshake completes) but never assert wb_we for them.
REQ-019 SHALL give handshake-to-wb_we latency of one posedge; register file commits on following negedge.
REQ-020 SHALL set busy[alloc_addr] at posedge when alloc_valid and alloc_addr != 0.
REQ-021 SHALL clear busy[m_addr] at posedge on m handshake; same-cycle alloc and clear of same addr leaves busy set.
REQ-022 SHALL drive chk_busy_n = busy[chk_addr_n]; always 0 for address 0.
REQ-023 SHALL set err at posedge on p handshake with p_addr != 0 and busy[p_addr]; cleared only by reset.

Reset
REQ-024 SHALL on rst clear busy[31:1], starve_cnt, err, wb_we, wb_addr, wb_data to 0 immediately.
REQ-025 SHALL drop any unaccepted request present at reset; requesters reissue after rst deasserts.
REQ-026 SHALL hold p_ready = 1, m_ready = 0 while rst asserted.

Configuration
REQ-027 SHALL, with WBARB_BUSY_BYPASS_EN defined, drive chk_busy_n low in the same cycle an m handshake targets chk_addr_n (unless same-cycle alloc of it).
REQ-028 SHALL, without WBARB_BUSY_BYPASS_EN, deassert chk_busy_n only the cycle after the clearing handshake.

Structure
REQ-029 SHALL take register-address width (5), data width (64) and STARVE_LIMIT default from the shared core package.
REQ-030 SHALL implement the 31-entry busy vector with lookup/bypass as sub-module reg_busy_table; arbitration and wb registers in the top.

Verification
REQ-031 SHALL check: p_valid=1 addr=5 data=0xAA, m idle -> p_ready=1; next posedge wb_we=1 wb_addr=5 wb_data=0xAA.
REQ-032 SHALL check: p_valid held 1 continuously, m_valid=1 addr=7 -> m_ready=1 in the 5th cycle (starve_cnt=4), p_ready=0 that cycle, wb_addr=7 next.
REQ-033 SHALL check: alloc addr=9, chk_addr_1=9 -> chk_busy_1=1 from next cycle; m handshake addr=9 -> chk_busy_1=0 same cycle with macro, next cycle without.
REQ-034 SHALL check: p handshake addr=0 data=0xFF -> p_ready=1, wb_we stays 0.
REQ-035 SHALL check: alloc addr=3 then p handshake addr=3 -> err=1 next posedge, stays 1 until rst.
REQ-036 SHALL check: rst pulsed mid-stream with busy[3]=1, wb_we=1 -> all outputs/busy 0 asynchronously, arbitration resumes cleanly after release.
